// File: rtl/tile_seq_gen.sv
// Tile-descriptor sequencer: walks an MxNxK tiled GEMM space into a small lookahead queue.
// Optional statistics counters are enabled with `define TILE_SEQ_STATS_EN.
module tile_seq_gen #(
  parameter int unsigned IDX_WIDTH       = 16,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 loop_order,
  input  logic [IDX_WIDTH-1:0] dim_M,
  input  logic [IDX_WIDTH-1:0] dim_N,
  input  logic [IDX_WIDTH-1:0] dim_K,
  input  logic [IDX_WIDTH-1:0] TM,
  input  logic [IDX_WIDTH-1:0] TN,
  input  logic [IDX_WIDTH-1:0] TK,
  output logic                 desc_valid,
  input  logic                 desc_ready,
  output logic [IDX_WIDTH-1:0] desc_i,
  output logic [IDX_WIDTH-1:0] desc_j,
  output logic [IDX_WIDTH-1:0] desc_k,
  output logic [IDX_WIDTH-1:0] desc_eTM,
  output logic [IDX_WIDTH-1:0] desc_eTN,
  output logic [IDX_WIDTH-1:0] desc_eTK,
  output logic                 desc_first_k,
  output logic                 desc_last_k,
  output logic                 desc_last,
  input  logic                 tile_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 ack_err
`ifdef TILE_SEQ_STATS_EN
  ,
  output logic [31:0]          stat_tiles,
  output logic [31:0]          stat_stalls
`endif
);

  localparam int unsigned W  = IDX_WIDTH;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned EW = 6 * W + 3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGen   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  dim_m_q, dim_n_q, dim_k_q, tm_q, tn_q, tk_q;
  logic          order_q;
  logic [W-1:0]  gi_q, gj_q, gk_q, gi_d, gj_d, gk_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_q, out_d;
  logic          cfg_err_q, ack_err_q;

  logic          cfg_zero, start_ok, start_idle;
  logic [W:0]    i_sum, j_sum, k_sum;
  logic          i_last, j_last, last_k, first_k, last_all;
  logic [W-1:0]  etm, etn, etk;
  logic [EW-1:0] gen_desc;
  logic          os_full, pop, push, ack_ok;

  assign cfg_zero   = (dim_M == '0) || (dim_N == '0) || (dim_K == '0) ||
                      (TM == '0) || (TN == '0) || (TK == '0);
  assign start_idle = (state_q == StIdle) && start;
  assign start_ok   = start_idle && !cfg_zero;

  // One bit of headroom so origin+tile never wraps near the top of the index range.
  assign i_sum = {1'b0, gi_q} + {1'b0, tm_q};
  assign j_sum = {1'b0, gj_q} + {1'b0, tn_q};
  assign k_sum = {1'b0, gk_q} + {1'b0, tk_q};

  assign i_last   = i_sum >= {1'b0, dim_m_q};
  assign j_last   = j_sum >= {1'b0, dim_n_q};
  assign last_k   = k_sum >= {1'b0, dim_k_q};
  assign first_k  = (gk_q == '0);
  assign last_all = last_k && i_last && j_last;

  assign etm = i_last ? (dim_m_q - gi_q) : tm_q;
  assign etn = j_last ? (dim_n_q - gj_q) : tn_q;
  assign etk = last_k ? (dim_k_q - gk_q) : tk_q;

  assign gen_desc = {gi_q, gj_q, gk_q, etm, etn, etk, first_k, last_k, last_all};

  assign os_full    = (out_q == OW'(MAX_OUTSTANDING));
  assign desc_valid = (cnt_q != '0) && !os_full;
  assign pop        = desc_valid && desc_ready;
  assign push       = (state_q == StGen) && ((cnt_q < CW'(DEPTH)) || pop);
  assign ack_ok     = tile_ack && (out_q != '0);

  assign {desc_i, desc_j, desc_k, desc_eTM, desc_eTN, desc_eTK,
          desc_first_k, desc_last_k, desc_last} = mem_q[rd_ptr_q];

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign cfg_err = cfg_err_q;
  assign ack_err = ack_err_q;

  // k is always innermost; loop_order only swaps which of i/j is the middle loop.
  always_comb begin
    gi_d = gi_q;
    gj_d = gj_q;
    gk_d = gk_q;
    if (start_ok) begin
      gi_d = '0;
      gj_d = '0;
      gk_d = '0;
    end else if (push) begin
      if (!last_k) begin
        gk_d = k_sum[W-1:0];
      end else begin
        gk_d = '0;
        if (!order_q) begin
          if (!j_last) begin
            gj_d = j_sum[W-1:0];
          end else begin
            gj_d = '0;
            gi_d = i_sum[W-1:0];
          end
        end else begin
          if (!i_last) begin
            gi_d = i_sum[W-1:0];
          end else begin
            gi_d = '0;
            gj_d = j_sum[W-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_ok) state_d = StGen;
      StGen:   if (push && last_all) state_d = StDrain;
      StDrain: if ((cnt_q == '0) && (out_q == '0)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    out_d = out_q;
    if (pop && !ack_ok) begin
      out_d = out_q + OW'(1);
    end else if (!pop && ack_ok) begin
      out_d = out_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dim_m_q   <= '0;
      dim_n_q   <= '0;
      dim_k_q   <= '0;
      tm_q      <= '0;
      tn_q      <= '0;
      tk_q      <= '0;
      order_q   <= 1'b0;
      gi_q      <= '0;
      gj_q      <= '0;
      gk_q      <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      cfg_err_q <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gi_q      <= gi_d;
      gj_q      <= gj_d;
      gk_q      <= gk_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      cfg_err_q <= start_idle && cfg_zero;
      if (start_ok) begin
        dim_m_q <= dim_M;
        dim_n_q <= dim_N;
        dim_k_q <= dim_K;
        tm_q    <= TM;
        tn_q    <= TN;
        tk_q    <= TK;
        order_q <= loop_order;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (tile_ack && (out_q == '0)) begin
        ack_err_q <= 1'b1;
      end else if (start_idle) begin
        ack_err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        mem_q[e] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= gen_desc;
    end
  end

`ifdef TILE_SEQ_STATS_EN
  logic [31:0] stat_tiles_q, stat_stalls_q;

  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      stat_tiles_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (pop && (stat_tiles_q != '1)) stat_tiles_q <= stat_tiles_q + 32'd1;
      if (desc_valid && !desc_ready && (stat_stalls_q != '1)) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign stat_tiles  = stat_tiles_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_tile_seq_gen.sv
// Randomised bench for tile_seq_gen: descriptors are checked against a loop-nest reference model.
module tb_tile_seq_gen;

  localparam int W    = 16;
  localparam int MAXO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         loop_order = 1'b0;
  logic [W-1:0] dim_M = '0, dim_N = '0, dim_K = '0, TM = '0, TN = '0, TK = '0;
  logic         desc_valid, desc_ready = 1'b0;
  logic [W-1:0] desc_i, desc_j, desc_k, desc_eTM, desc_eTN, desc_eTK;
  logic         desc_first_k, desc_last_k, desc_last;
  logic         tile_ack = 1'b0;
  logic         busy, done, cfg_err, ack_err;

  tile_seq_gen #(.IDX_WIDTH(W), .DEPTH(4), .MAX_OUTSTANDING(MAXO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .loop_order   (loop_order),
    .dim_M        (dim_M),
    .dim_N        (dim_N),
    .dim_K        (dim_K),
    .TM           (TM),
    .TN           (TN),
    .TK           (TK),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_i       (desc_i),
    .desc_j       (desc_j),
    .desc_k       (desc_k),
    .desc_eTM     (desc_eTM),
    .desc_eTN     (desc_eTN),
    .desc_eTK     (desc_eTK),
    .desc_first_k (desc_first_k),
    .desc_last_k  (desc_last_k),
    .desc_last    (desc_last),
    .tile_ack     (tile_ack),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err),
    .ack_err      (ack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i; int j; int k; int etm; int etn; int etk;
    bit fk; bit lk; bit last;
  } desc_t;

  desc_t       exp_q[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          model_out = 0;
  int          n_hs = 0;
  bit          hold_pend = 1'b0;
  logic [98:0] held;

  function automatic logic [98:0] obs_all();
    return {desc_i, desc_j, desc_k, desc_eTM, desc_eTN, desc_eTK,
            desc_first_k, desc_last_k, desc_last};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain loop nest over outer/middle/k with clipped tile sizes.
  task automatic build(input int m, input int n, input int kd, input int tm, input int tn,
                       input int tk, input bit ord);
    int od, to, md, tmid;
    desc_t d;
    exp_q.delete();
    od   = ord ? n : m;
    to   = ord ? tn : tm;
    md   = ord ? m : n;
    tmid = ord ? tm : tn;
    for (int o = 0; o < od; o += to) begin
      for (int mm = 0; mm < md; mm += tmid) begin
        for (int kk = 0; kk < kd; kk += tk) begin
          d.i    = ord ? mm : o;
          d.j    = ord ? o : mm;
          d.k    = kk;
          d.etm  = imin(tm, m - d.i);
          d.etn  = imin(tn, n - d.j);
          d.etk  = imin(tk, kd - kk);
          d.fk   = (kk == 0);
          d.lk   = (kk + tk >= kd);
          d.last = d.lk && (o + to >= od) && (mm + tmid >= md);
          exp_q.push_back(d);
        end
      end
    end
  endtask

  // One clock cycle: drive, check what the consumer sees, then advance past the edge.
  task automatic cyc(input bit rdy, input bit ack);
    bit          hs;
    bit          ack_eff;
    logic [98:0] o;
    desc_t       d;
    desc_ready = rdy;
    tile_ack   = ack;
    o = obs_all();
    if (model_out == MAXO) check("bp_valid", 64'(desc_valid), 64'd0);
    if (hold_pend) begin
      check("hold_valid", 64'(desc_valid), 64'd1);
      check("hold_pos", 64'(o[98:51]), 64'(held[98:51]));
      check("hold_size", 64'(o[50:0]), 64'(held[50:0]));
    end
    hs        = desc_valid && rdy;
    hold_pend = desc_valid && !rdy;
    held      = o;
    if (hs) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        check("extra_desc", 64'(hs), 64'd0);
      end else begin
        d = exp_q.pop_front();
        check("pos", 64'({desc_i, desc_j, desc_k}), 64'({W'(d.i), W'(d.j), W'(d.k)}));
        check("size", 64'({desc_eTM, desc_eTN, desc_eTK}),
              64'({W'(d.etm), W'(d.etn), W'(d.etk)}));
        check("flags", 64'({desc_first_k, desc_last_k, desc_last}), 64'({d.fk, d.lk, d.last}));
      end
    end
    ack_eff   = ack && (model_out > 0);
    model_out = model_out + int'(hs) - int'(ack_eff);
    @(posedge clk);
    #1;
    tile_ack = 1'b0;
  endtask

  task automatic start_op(input int m, input int n, input int kd, input int tm, input int tn,
                          input int tk, input bit ord);
    build(m, n, kd, tm, tn, tk, ord);
    n_hs      = 0;
    hold_pend = 1'b0;
    dim_M = W'(m); dim_N = W'(n); dim_K = W'(kd);
    TM = W'(tm); TN = W'(tn); TK = W'(tk);
    loop_order = ord;
    start = 1'b1;
    cyc(1'b0, 1'b0);
    start = 1'b0;
    check("lat1_valid", 64'(desc_valid), 64'd0);
    check("busy_on", 64'(busy), 64'd1);
    check("ack_err_clr", 64'(ack_err), 64'd0);
    cyc(1'b0, 1'b0);
    check("lat2_valid", 64'(desc_valid), 64'd1);
  endtask

  task automatic finish_op(input int rpct, input int apct, input bit strict);
    bit seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
        check("left_desc", 64'(exp_q.size()), 64'd0);
        check("left_out", 64'(model_out), 64'd0);
        check("done_busy", 64'(busy), 64'd1);
        cyc(1'b0, 1'b0);
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
      end else begin
        if (strict && exp_q.size() != 0) check("tput", 64'(desc_valid), 64'd1);
        cyc(($urandom % 100) < rpct, (model_out > 0) && (($urandom % 100) < apct));
      end
    end
    if (!seen) check("timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", 64'(desc_valid), 64'd0);
    check("rst_flags", 64'({busy, done, cfg_err, ack_err}), 64'd0);
    check("rst_fields", 64'(obs_all() != '0), 64'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);

    // Order 0 walk with clipped M and K edges, full-rate consumer.
    start_op(5, 4, 6, 2, 4, 4, 1'b0);
    finish_op(100, 100, 1'b1);

    // Same space, both loop orders.
    start_op(4, 8, 4, 4, 4, 4, 1'b1);
    finish_op(100, 100, 1'b1);
    start_op(4, 8, 4, 4, 4, 4, 1'b0);
    finish_op(100, 100, 1'b1);

    // Consumer stalled: queue fills, head held, then flows at full rate.
    start_op(5, 4, 6, 2, 4, 4, 1'b0);
    repeat (20) cyc(1'b0, 1'b0);
    check("stall_valid", 64'(desc_valid), 64'd1);
    check("stall_head", 64'({desc_i, desc_j, desc_k}),
          64'({W'(exp_q[0].i), W'(exp_q[0].j), W'(exp_q[0].k)}));
    finish_op(100, 100, 1'b1);

    // Outstanding limit.
    start_op(16, 16, 16, 4, 4, 4, 1'b0);
    repeat (12) cyc(1'b1, 1'b0);
    check("os_cap", 64'(n_hs), 64'd8);
    check("os_bp", 64'(desc_valid), 64'd0);
    cyc(1'b1, 1'b1);
    repeat (4) cyc(1'b1, 1'b0);
    check("os_one_more", 64'(n_hs), 64'd9);
    cyc(1'b0, 1'b1);
    check("os_reopen", 64'(desc_valid), 64'd1);
    cyc(1'b1, 1'b1);
    check("os_same", 64'(desc_valid), 64'd1);
    check("os_same_hs", 64'(n_hs), 64'd10);
    cyc(1'b1, 1'b0);
    check("os_full_again", 64'(desc_valid), 64'd0);
    check("os_full_hs", 64'(n_hs), 64'd11);
    finish_op(80, 50, 1'b0);

    // Zero-config rejection.
    dim_M = 4; dim_N = 4; dim_K = 4; TM = 2; TN = 2; TK = 0;
    start = 1'b1;
    cyc(1'b0, 1'b0);
    start = 1'b0;
    check("cfg_err_pulse", 64'(cfg_err), 64'd1);
    check("cfg_busy", 64'(busy), 64'd0);
    check("cfg_valid", 64'(desc_valid), 64'd0);
    cyc(1'b0, 1'b0);
    check("cfg_err_end", 64'(cfg_err), 64'd0);
    check("cfg_quiet", 64'({busy, desc_valid, done}), 64'd0);

    // Stray ack in IDLE is sticky until the next start.
    cyc(1'b0, 1'b1);
    check("ack_err_set", 64'(ack_err), 64'd1);
    repeat (3) cyc(1'b0, 1'b0);
    check("ack_err_hold", 64'(ack_err), 64'd1);
    start_op(3, 3, 3, 2, 2, 2, 1'b1);
    finish_op(60, 60, 1'b0);

    // Reset mid-operation, then a fresh run from the origin.
    start_op(5, 4, 6, 2, 4, 4, 1'b0);
    for (int c = 0; c < 50 && n_hs < 3; c++) cyc(1'b1, model_out > 0);
    check("rst_pre_hs", 64'(n_hs), 64'd3);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    model_out = 0;
    hold_pend = 1'b0;
    check("mid_rst_valid", 64'(desc_valid), 64'd0);
    check("mid_rst_flags", 64'({busy, done, cfg_err, ack_err}), 64'd0);
    check("mid_rst_fields", 64'(obs_all() != '0), 64'd0);
    start_op(5, 4, 6, 2, 4, 4, 1'b0);
    finish_op(100, 100, 1'b1);

    // Sums near the top of the index range.
    start_op(65535, 1, 3, 40000, 1, 2, 1'b0);
    finish_op(70, 70, 1'b0);

    for (int r = 0; r < 8; r++) begin
      start_op(1 + int'($urandom % 10), 1 + int'($urandom % 10), 1 + int'($urandom % 10),
               1 + int'($urandom % 5), 1 + int'($urandom % 5), 1 + int'($urandom % 5),
               1'($urandom % 2));
      finish_op(30 + int'($urandom % 71), 20 + int'($urandom % 71), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
